npu_axil_regs: RTL and testbench

AXI-Lite slave register block for the NPU control plane. It decodes the 12-bit register map: CTRL, STATUS, CLUSTER_EN, PE_EN_0..3 and CONFIG. It drives start/clear pulses and enable/config vectors into the NPU core, and samples the core's busy/done/error status. It sits between the host AXI-Lite interconnect and the NPU top-level controller.

---
 rtl/npu_axil_regs.sv | 270 +++++++++++++++++++++++++++
 tb/tb_npu_axil_regs.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_axil_regs.sv
// npu_axil_regs: AXI-Lite slave register block for the NPU control plane.
// Register map (word index = addr[4:2]; addr[11:5] must be zero):
//   0 CTRL (W1 pulse: bit0 start, bit1 clear), 1 STATUS (busy/done/error),
//   2 CLUSTER_EN, 3..6 PE_EN_0..3, 7 CONFIG.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   s_axil_aw*/w*/b*       AXI-Lite write address / data / response channels
//   s_axil_ar*/r*          AXI-Lite read address / data channels
//   busy_i/done_i/error_i  core status (done/error are single-cycle pulses)
//   start_o/clear_o        one-cycle pulses to the core
//   cluster_en_o, pe_en_o, config_o  register contents driven to the core
module npu_axil_regs #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     s_axil_awaddr,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [DATA_WIDTH-1:0]     s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axil_wstrb,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axil_araddr,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  output logic [DATA_WIDTH-1:0]     s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  input  logic                      busy_i,
  input  logic                      done_i,
  input  logic                      error_i,
  output logic                      start_o,
  output logic                      clear_o,
  output logic [3:0]                cluster_en_o,
  output logic [15:0]               pe_en_o,
  output logic [31:0]               config_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_COMMIT = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;

  logic                  r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]            r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_aw_held, r_w_held;
  logic [ADDR_WIDTH-3:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;

  logic [3:0]  r_cluster_en, r_pe_en_0, r_pe_en_1, r_pe_en_2, r_pe_en_3;
  logic [31:0] r_config;
  logic        r_start, r_clear, r_done, r_error;

  logic w_aw_hs, w_w_hs, w_ar_hs, w_aw_have, w_w_have;
  logic w_aw_held_nxt, w_w_held_nxt, w_awready_nxt, w_wready_nxt, w_bvalid_nxt;
  logic w_wr_mapped, w_rd_mapped;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [3:0]  w_cluster_en_nxt, w_pe_en_0_nxt, w_pe_en_1_nxt, w_pe_en_2_nxt, w_pe_en_3_nxt;
  logic [31:0] w_config_nxt;
  logic        w_pulse_start, w_pulse_clear, w_start_busy, w_clr_sticky;
  logic        w_unused_addr;

  // Byte-offset address bits carry no information for word registers.
  assign w_unused_addr = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  assign w_aw_hs   = s_axil_awvalid & r_awready;
  assign w_w_hs    = s_axil_wvalid & r_wready;
  assign w_ar_hs   = s_axil_arvalid & r_arready;
  assign w_aw_have = r_aw_held | w_aw_hs;
  assign w_w_have  = r_w_held | w_w_hs;

  assign w_wr_mapped = (r_awaddr[ADDR_WIDTH-3:3] == '0);
  assign w_rd_mapped = (s_axil_araddr[ADDR_WIDTH-1:5] == '0);

  // Write FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wstate <= W_IDLE;
    else     r_wstate <= w_wstate_nxt;
  end

  // Write FSM: next state
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:   if (w_aw_have && w_w_have) w_wstate_nxt = W_COMMIT;
      W_COMMIT: w_wstate_nxt = W_RESP;
      W_RESP:   if (s_axil_bready) w_wstate_nxt = W_IDLE;
      default:  w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write FSM: outputs (next values of the registered channel signals)
  always_comb begin
    w_aw_held_nxt = w_aw_have;
    w_w_held_nxt  = w_w_have;
    if (r_wstate == W_RESP && s_axil_bready) begin
      w_aw_held_nxt = 1'b0;
      w_w_held_nxt  = 1'b0;
    end
    w_awready_nxt = (w_wstate_nxt == W_IDLE) && !w_aw_held_nxt;
    w_wready_nxt  = (w_wstate_nxt == W_IDLE) && !w_w_held_nxt;
    w_bvalid_nxt  = (w_wstate_nxt == W_RESP);
  end

  // Write channel registers and captured AW/W payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      if (w_aw_hs) r_awaddr <= s_axil_awaddr[ADDR_WIDTH-1:2];
      if (w_w_hs) begin
        r_wdata <= s_axil_wdata;
        r_wstrb <= s_axil_wstrb;
      end
      if (r_wstate == W_COMMIT) r_bresp <= w_wr_mapped ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Commit datapath: register updates and CTRL pulse decode (clear beats start)
  always_comb begin
    w_cluster_en_nxt = r_cluster_en;
    w_pe_en_0_nxt    = r_pe_en_0;
    w_pe_en_1_nxt    = r_pe_en_1;
    w_pe_en_2_nxt    = r_pe_en_2;
    w_pe_en_3_nxt    = r_pe_en_3;
    w_config_nxt     = r_config;
    w_pulse_start    = 1'b0;
    w_pulse_clear    = 1'b0;
    w_start_busy     = 1'b0;
    if (r_wstate == W_COMMIT && w_wr_mapped) begin
      case (r_awaddr[2:0])
        3'd0: if (r_wstrb[0]) begin
          if (r_wdata[1])      w_pulse_clear = 1'b1;
          else if (r_wdata[0]) begin
            if (busy_i) w_start_busy  = 1'b1;
            else        w_pulse_start = 1'b1;
          end
        end
        3'd2: if (r_wstrb[0]) w_cluster_en_nxt = r_wdata[3:0];
        3'd3: if (r_wstrb[0]) w_pe_en_0_nxt = r_wdata[3:0];
        3'd4: if (r_wstrb[0]) w_pe_en_1_nxt = r_wdata[3:0];
        3'd5: if (r_wstrb[0]) w_pe_en_2_nxt = r_wdata[3:0];
        3'd6: if (r_wstrb[0]) w_pe_en_3_nxt = r_wdata[3:0];
        3'd7: for (int b = 0; b < 4; b++)
                if (r_wstrb[b]) w_config_nxt[8*b +: 8] = r_wdata[8*b +: 8];
        default: ;
      endcase
    end
  end

  assign w_clr_sticky = w_pulse_start | w_pulse_clear;

  // Register file, pulses and sticky status (a set in the same cycle as a clear wins)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cluster_en <= '0;
      r_pe_en_0    <= '0;
      r_pe_en_1    <= '0;
      r_pe_en_2    <= '0;
      r_pe_en_3    <= '0;
      r_config     <= '0;
      r_start      <= 1'b0;
      r_clear      <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_cluster_en <= w_cluster_en_nxt;
      r_pe_en_0    <= w_pe_en_0_nxt;
      r_pe_en_1    <= w_pe_en_1_nxt;
      r_pe_en_2    <= w_pe_en_2_nxt;
      r_pe_en_3    <= w_pe_en_3_nxt;
      r_config     <= w_config_nxt;
      r_start      <= w_pulse_start;
      r_clear      <= w_pulse_clear;
      r_done       <= done_i | (r_done & ~w_clr_sticky);
      r_error      <= error_i | w_start_busy | (r_error & ~w_clr_sticky);
    end
  end

  // Read mux; STATUS busy is live, done/error are the sticky copies
  always_comb begin
    w_rd_data = '0;
    if (w_rd_mapped) begin
      case (s_axil_araddr[4:2])
        3'd1:    w_rd_data = DATA_WIDTH'({r_error, r_done, busy_i});
        3'd2:    w_rd_data = DATA_WIDTH'(r_cluster_en);
        3'd3:    w_rd_data = DATA_WIDTH'(r_pe_en_0);
        3'd4:    w_rd_data = DATA_WIDTH'(r_pe_en_1);
        3'd5:    w_rd_data = DATA_WIDTH'(r_pe_en_2);
        3'd6:    w_rd_data = DATA_WIDTH'(r_pe_en_3);
        3'd7:    w_rd_data = DATA_WIDTH'(r_config);
        default: w_rd_data = '0;
      endcase
    end
  end

  // Read FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rstate <= R_IDLE;
    else     r_rstate <= w_rstate_nxt;
  end

  // Read FSM: next state
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (s_axil_rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read FSM: registered outputs; data/resp only change on an AR handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_arready <= (w_rstate_nxt == R_IDLE);
      r_rvalid  <= (w_rstate_nxt == R_DATA);
      if (w_ar_hs) begin
        r_rdata <= w_rd_data;
        r_rresp <= w_rd_mapped ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign s_axil_awready = r_awready;
  assign s_axil_wready  = r_wready;
  assign s_axil_bvalid  = r_bvalid;
  assign s_axil_bresp   = r_bresp;
  assign s_axil_arready = r_arready;
  assign s_axil_rvalid  = r_rvalid;
  assign s_axil_rdata   = r_rdata;
  assign s_axil_rresp   = r_rresp;
  assign start_o        = r_start;
  assign clear_o        = r_clear;
  assign cluster_en_o   = r_cluster_en;
  assign pe_en_o        = {r_pe_en_3, r_pe_en_2, r_pe_en_1, r_pe_en_0};
  assign config_o       = r_config;

endmodule

// File: tb/tb_npu_axil_regs.sv
// Testbench for npu_axil_regs: table of AXI-Lite write/read vectors plus
// hand-written sequences for reset, channel ordering, start/clear/status
// behaviour and response backpressure.
module tb_npu_axil_regs;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [11:0] s_axil_awaddr;
  logic        s_axil_awvalid, s_axil_awready;
  logic [31:0] s_axil_wdata;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_wvalid, s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid, s_axil_bready;
  logic [11:0] s_axil_araddr;
  logic        s_axil_arvalid, s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid, s_axil_rready;
  logic        busy_i, done_i, error_i;
  logic        start_o, clear_o;
  logic [3:0]  cluster_en_o;
  logic [15:0] pe_en_o;
  logic [31:0] config_o;

  npu_axil_regs #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
    .s_axil_rready(s_axil_rready),
    .busy_i(busy_i), .done_i(done_i), .error_i(error_i),
    .start_o(start_o), .clear_o(clear_o),
    .cluster_en_o(cluster_en_o), .pe_en_o(pe_en_o), .config_o(config_o)
  );

  int total = 0;
  int bad   = 0;
  int n_start = 0, n_clear = 0, n_bhs = 0;

  // Count pulse cycles and B handshakes (sampled mid-cycle)
  always @(negedge clk) begin
    if (!rst) begin
      if (start_o) n_start++;
      if (clear_o) n_clear++;
      if (s_axil_bvalid && s_axil_bready) n_bhs++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drive AW and W; W may lead AW by w_lead cycles. Returns at the negedge after the last handshake.
  task automatic send_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, input int w_lead);
    int   cyc;
    logic aw_done, w_done, aw_f, w_f;
    cyc = 0; aw_done = 1'b0; w_done = 1'b0;
    s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
    s_axil_wvalid = 1'b1; s_axil_awvalid = (w_lead == 0);
    while (!(aw_done && w_done) && cyc < 40) begin
      aw_f = s_axil_awvalid && s_axil_awready;
      w_f  = s_axil_wvalid && s_axil_wready;
      @(negedge clk); cyc++;
      if (aw_f) begin s_axil_awvalid = 1'b0; aw_done = 1'b1; end
      if (w_f)  begin s_axil_wvalid  = 1'b0; w_done  = 1'b1; end
      if (!aw_done && cyc >= w_lead) s_axil_awvalid = 1'b1;
    end
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    chk("wr_accept", 32'(aw_done && w_done), 32'd1);
  endtask

  // Wait for bvalid; sample bresp and {clear_o,start_o} in the first bvalid cycle.
  task automatic wait_b(output logic [1:0] resp, output logic [1:0] pulses);
    int cyc;
    cyc = 0;
    while (!s_axil_bvalid && cyc < 20) begin @(negedge clk); cyc++; end
    chk("bvalid_seen", 32'(s_axil_bvalid), 32'd1);
    chk("bvalid_lat", 32'(cyc), 32'd1);
    resp = s_axil_bresp; pulses = {clear_o, start_o};
    if (s_axil_bready) @(negedge clk);
  endtask

  // Read; optionally pulse done_i in the AR handshake cycle.
  task automatic do_read(input logic [11:0] a, input bit pulse_done,
                         output logic [31:0] d, output logic [1:0] r);
    int   cyc;
    logic fired;
    cyc = 0; fired = 1'b0;
    s_axil_araddr = a; s_axil_arvalid = 1'b1;
    while (!fired && cyc < 20) begin
      fired = s_axil_arready;
      if (fired && pulse_done) done_i = 1'b1;
      @(negedge clk); cyc++;
    end
    s_axil_arvalid = 1'b0; done_i = 1'b0;
    chk("ar_accept", 32'(fired), 32'd1);
    chk("rvalid_lat", 32'(s_axil_rvalid), 32'd1);
    d = s_axil_rdata; r = s_axil_rresp;
    if (s_axil_rready) @(negedge clk);
  endtask

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  localparam int unsigned NVEC = 16;
  vec_t vecs [NVEC];

  initial begin
    logic [31:0] d;
    logic [1:0]  r, p;
    int          snap_s, snap_c, snap_b;
    logic        ok;

    vecs[0]  = '{1'b1, 12'h01C, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00};
    vecs[1]  = '{1'b1, 12'h01C, 32'h00001100, 4'h2, 32'h0,        2'b00};
    vecs[2]  = '{1'b0, 12'h01C, 32'h0,        4'h0, 32'hDEAD11EF, 2'b00};
    vecs[3]  = '{1'b1, 12'h008, 32'hFFFFFFF5, 4'hF, 32'h0,        2'b00};
    vecs[4]  = '{1'b0, 12'h008, 32'h0,        4'h0, 32'h00000005, 2'b00};
    vecs[5]  = '{1'b1, 12'h00C, 32'h0000000A, 4'h1, 32'h0,        2'b00};
    vecs[6]  = '{1'b0, 12'h00C, 32'h0,        4'h0, 32'h0000000A, 2'b00};
    vecs[7]  = '{1'b1, 12'h014, 32'h00000003, 4'h2, 32'h0,        2'b00};
    vecs[8]  = '{1'b0, 12'h014, 32'h0,        4'h0, 32'h00000000, 2'b00};
    vecs[9]  = '{1'b1, 12'h018, 32'h0000000C, 4'hF, 32'h0,        2'b00};
    vecs[10] = '{1'b0, 12'h018, 32'h0,        4'h0, 32'h0000000C, 2'b00};
    vecs[11] = '{1'b0, 12'h020, 32'h0,        4'h0, 32'h00000000, 2'b10};
    vecs[12] = '{1'b1, 12'h100, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b10};
    vecs[13] = '{1'b0, 12'h01F, 32'h0,        4'h0, 32'hDEAD11EF, 2'b00};
    vecs[14] = '{1'b0, 12'h000, 32'h0,        4'h0, 32'h00000000, 2'b00};
    vecs[15] = '{1'b0, 12'hFFC, 32'h0,        4'h0, 32'h00000000, 2'b10};

    s_axil_awaddr = '0; s_axil_awvalid = 1'b0; s_axil_wdata = '0; s_axil_wstrb = '0;
    s_axil_wvalid = 1'b0; s_axil_bready = 1'b1; s_axil_araddr = '0; s_axil_arvalid = 1'b0;
    s_axil_rready = 1'b1; busy_i = 1'b0; done_i = 1'b0; error_i = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    idle(3);

    // Reset values
    chk("rst_ready", 32'({s_axil_awready, s_axil_wready, s_axil_arready}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'({s_axil_awready, s_axil_wready, s_axil_arready}), 32'h7);

    // Reset mid-write aborts the transaction and clears everything
    send_wr(12'h008, 32'hF, 4'hF, 0); wait_b(r, p);
    chk("pre_rst_cluster", 32'(cluster_en_o), 32'hF);
    s_axil_awaddr = 12'h01C; s_axil_wdata = 32'h12345678; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_ctl_outs", 32'({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid,
                             s_axil_rvalid, start_o, clear_o, s_axil_bresp, s_axil_rresp}), 32'd0);
    chk("rst_cluster", 32'(cluster_en_o), 32'd0);
    chk("rst_pe", 32'(pe_en_o), 32'd0);
    chk("rst_config", config_o, 32'd0);
    chk("rst_rdata", s_axil_rdata, 32'd0);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    idle(2);
    snap_b = n_bhs;
    rst = 1'b0;
    idle(5);
    chk("rst_no_bresp", 32'(n_bhs - snap_b), 32'd0);
    do_read(12'h008, 1'b0, d, r);
    chk("rst_rd_cluster", d, 32'd0); chk("rst_rd_cluster_resp", 32'(r), 32'd0);
    do_read(12'h01C, 1'b0, d, r);
    chk("rst_rd_config", d, 32'd0);

    // Table-driven register accesses
    for (int i = 0; i < int'(NVEC); i++) begin
      if (vecs[i].wr) begin
        send_wr(vecs[i].addr, vecs[i].data, vecs[i].strb, 0);
        wait_b(r, p);
        chk($sformatf("v%0d_bresp", i), 32'(r), 32'(vecs[i].exp_resp));
      end else begin
        do_read(vecs[i].addr, 1'b0, d, r);
        chk($sformatf("v%0d_rdata", i), d, vecs[i].exp_data);
        chk($sformatf("v%0d_rresp", i), 32'(r), 32'(vecs[i].exp_resp));
      end
    end
    chk("tbl_config_o", config_o, 32'hDEAD11EF);
    chk("tbl_pe_en_o", 32'(pe_en_o), 32'h0000C00A);
    chk("tbl_cluster_o", 32'(cluster_en_o), 32'h5);

    // W leads AW by 3 cycles
    snap_b = n_bhs;
    send_wr(12'h010, 32'h5, 4'hF, 3); wait_b(r, p);
    idle(3);
    chk("order_bresp", 32'(r), 32'd0);
    chk("order_one_b", 32'(n_bhs - snap_b), 32'd1);
    chk("order_pe_en_o", 32'(pe_en_o), 32'h0000C05A);

    // Start, done, clear
    snap_s = n_start; snap_c = n_clear;
    send_wr(12'h000, 32'h1, 4'hF, 0); wait_b(r, p);
    chk("start_at_b", 32'(p), 32'b01);
    idle(3);
    chk("start_once", 32'(n_start - snap_s), 32'd1);
    done_i = 1'b1; @(negedge clk); done_i = 1'b0;
    do_read(12'h004, 1'b0, d, r);
    chk("status_done", d, 32'h2);
    send_wr(12'h000, 32'h2, 4'hF, 0); wait_b(r, p);
    chk("clear_at_b", 32'(p), 32'b10);
    idle(2);
    chk("clear_once", 32'(n_clear - snap_c), 32'd1);
    do_read(12'h004, 1'b0, d, r);
    chk("status_cleared", d, 32'h0);

    // done_i in the AR handshake cycle shows up only in the next read
    do_read(12'h004, 1'b1, d, r);
    chk("status_same_cyc", d, 32'h0);
    do_read(12'h004, 1'b0, d, r);
    chk("status_next_rd", d, 32'h2);

    // CTRL ignored without wstrb[0]
    snap_s = n_start;
    send_wr(12'h000, 32'h1, 4'h2, 0); wait_b(r, p);
    idle(2);
    chk("ctrl_nostrb", 32'(n_start - snap_s), 32'd0);

    // Start while busy
    busy_i = 1'b1;
    snap_s = n_start; snap_c = n_clear;
    send_wr(12'h000, 32'h1, 4'hF, 0); wait_b(r, p);
    chk("busy_start_resp", 32'(r), 32'd0);
    chk("busy_start_pulses", 32'(p), 32'b00);
    do_read(12'h004, 1'b0, d, r);
    chk("busy_status", d, 32'h7);
    send_wr(12'h000, 32'h3, 4'hF, 0); wait_b(r, p);
    chk("clr_wins_pulses", 32'(p), 32'b10);
    idle(2);
    chk("busy_no_start", 32'(n_start - snap_s), 32'd0);
    chk("busy_one_clear", 32'(n_clear - snap_c), 32'd1);
    do_read(12'h004, 1'b0, d, r);
    chk("busy_status_clr", d, 32'h1);
    busy_i = 1'b0;

    // Error pulse sets sticky error
    error_i = 1'b1; @(negedge clk); error_i = 1'b0;
    do_read(12'h004, 1'b0, d, r);
    chk("status_err", d, 32'h4);

    // Read backpressure
    s_axil_rready = 1'b0;
    do_read(12'h01C, 1'b0, d, r);
    s_axil_araddr = 12'h008; s_axil_arvalid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!(s_axil_rvalid && s_axil_rdata == 32'hDEAD11EF && !s_axil_arready && s_axil_rresp == 2'b00))
        ok = 1'b0;
    end
    chk("rd_hold_stable", 32'(ok), 32'd1);
    s_axil_arvalid = 1'b0; s_axil_rready = 1'b1;
    @(negedge clk);
    chk("rd_hold_done", 32'(s_axil_rvalid), 32'd0);
    do_read(12'h008, 1'b0, d, r);
    chk("rd_after_hold", d, 32'h5);

    // Write backpressure on an unmapped address
    s_axil_bready = 1'b0;
    snap_b = n_bhs;
    send_wr(12'h100, 32'h0, 4'hF, 0); wait_b(r, p);
    chk("wr_unmapped_resp", 32'(r), 32'b10);
    s_axil_awaddr = 12'h008; s_axil_awvalid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!(s_axil_bvalid && s_axil_bresp == 2'b10 && !s_axil_awready)) ok = 1'b0;
    end
    chk("wr_hold_stable", 32'(ok), 32'd1);
    s_axil_awvalid = 1'b0; s_axil_bready = 1'b1;
    idle(3);
    chk("wr_hold_one_b", 32'(n_bhs - snap_b), 32'd1);
    chk("wr_unmapped_cfg", config_o, 32'hDEAD11EF);
    chk("wr_unmapped_pe", 32'(pe_en_o), 32'h0000C05A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
